// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: 8N1 UART receiver with majority-vote bit sampling, feeding a
// small first-word-fall-through byte FIFO with a valid/ready consumer port.
`timescale 1ns/1ps
module serial_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IN_SERIAL_RX,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       IN_READY,
    output logic [6:0] OUT_FIFO_COUNT,
    output logic       OUT_FRAME_ERR,
    output logic       OUT_OVERRUN
);

    localparam int unsigned MID = CLKS_PER_BIT / 2;
    localparam int unsigned TW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_A    = TW'(MID - 1);
    localparam logic [TW-1:0] T_B    = TW'(MID);
    localparam logic [TW-1:0] T_C    = TW'(MID + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t        state;
    logic          rx_meta, rx_s;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          samp_a, samp_b;
    logic          push_req;
    logic [7:0]    push_byte;
    logic          frame_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_d, count_w;
    logic [7:0]    out_data_q;
    logic          out_valid_q;
    logic          overrun_q;
    logic          full, pop, push_ok, at_dec, at_wrap, maj;

    // Third vote comes straight from the live synced line at the decision count.
    assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign at_dec  = (timer == T_C);
    assign at_wrap = (timer == T_LAST);

    // Two-flop synchronizer, preset to idle; sync_fill marks when rx_s reflects the real pin.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= IN_SERIAL_RX;
            rx_s      <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Receiver FSM: bit timing, majority sampling, byte assembly and stop-bit check.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= StIdle;
            timer     <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            armed     <= 1'b0;
            push_req  <= 1'b0;
            push_byte <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
            if (state != StIdle) begin
                timer <= at_wrap ? '0 : timer + TW'(1);
                if (timer == T_A) samp_a <= rx_s;
                if (timer == T_B) samp_b <= rx_s;
            end
            case (state)
                StIdle: begin
                    // Arm only after a genuine high has been seen (post-reset, post-break).
                    if (sync_fill[1] && rx_s) armed <= 1'b1;
                    if (armed && !rx_s) begin
                        state <= StStart;
                        timer <= '0;
                    end
                end
                StStart: begin
                    if (at_dec && maj) begin
                        state <= StIdle;
                    end else if (at_wrap) begin
                        state   <= StData;
                        bit_idx <= 3'd0;
                    end
                end
                StData: begin
                    if (at_dec) shreg[bit_idx] <= maj;
                    if (at_wrap) begin
                        if (bit_idx == 3'd7) state <= StStop;
                        else bit_idx <= bit_idx + 3'd1;
                    end
                end
                StStop: begin
                    // Leave at the decision point so a back-to-back start bit is caught.
                    if (at_dec) begin
                        state <= StIdle;
                        if (maj) begin
                            push_req  <= 1'b1;
                            push_byte <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign count_w  = wr_ptr - rd_ptr;
    assign full     = (count_w == (AW + 1)'(FIFO_DEPTH));
    assign pop      = out_valid_q & IN_READY;
    assign push_ok  = push_req & (~full | pop);
    assign rd_ptr_d = pop ? rd_ptr + (AW + 1)'(1) : rd_ptr;

    // Storage array; write only, no reset needed.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_byte;
    end

    // Pointers and registered head: head reads the pre-write array at the next read pointer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
            rd_ptr      <= rd_ptr_d;
            overrun_q   <= push_req & full & ~pop;
            out_valid_q <= (wr_ptr != rd_ptr_d);
            if (wr_ptr != rd_ptr_d) out_data_q <= mem[rd_ptr_d[AW-1:0]];
        end
    end

    assign OUT_DATA       = out_data_q;
    assign OUT_VALID      = out_valid_q;
    assign OUT_FIFO_COUNT = 7'(count_w);
    assign OUT_FRAME_ERR  = frame_err;
    assign OUT_OVERRUN    = overrun_q;

endmodule
